// File: rtl/session_req_sequencer_if.sv
// ---------------------------------------------------------------------------
// session_req_sequencer_if
//
// Generic valid/ready stream bundle used for every request and reply channel
// of session_req_sequencer. The payload width is set per instance.
//
// Signals:
//   tdata  [DATA_W-1:0]  payload, carried bit-exact
//   tvalid               producer has a beat
//   tready               consumer can take the beat
//
// Modports:
//   master  drives tdata/tvalid, samples tready
//   slave   samples tdata/tvalid, drives tready
// ---------------------------------------------------------------------------
interface session_req_sequencer_if #(
  parameter int DATA_W = 72
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/session_req_sequencer.sv
// ---------------------------------------------------------------------------
// session_req_sequencer
//
// Sits between the TOE session lookup logic and the cuckoo CAM. Lookup and
// update requests each pass through a one-entry registered slice; replies
// pass straight through. Lookups in flight are counted and capped at
// MAX_OUTSTANDING. An update is only let into its slice once every
// outstanding lookup has been answered, and no new request is accepted
// until that update has been answered.
//
// Parameters:
//   MAX_OUTSTANDING  lookups allowed in flight without a reply (1..15)
//
// Ports:
//   ap_clk, ap_rst           clock, synchronous active-high reset
//   s_axis_session_lup_req   slave,  72-bit lookup requests from the TOE
//   s_axis_session_upd_req   slave,  88-bit update requests from the TOE
//   m_lookup_request_V       master, 72-bit lookup requests to the CAM
//   m_update_request_V       master, 88-bit update requests to the CAM
//   s_lookup_reply_V         slave,  88-bit lookup replies from the CAM
//   s_update_replay_V        slave,  88-bit update replies from the CAM
//   m_axis_session_lup_rsp   master, 88-bit lookup replies to the TOE
//   m_axis_session_upd_rsp   master, 88-bit update replies to the TOE
//   outstanding [3:0]        lookups currently in flight
//
// Optional feature, enabled by defining macro SESSION_SEQ_STATS_EN:
//   stat_lup_cnt   [31:0]    accepted TOE lookup requests (wrapping)
//   stat_upd_cnt   [31:0]    accepted TOE update requests (wrapping)
//   stat_stall_cnt [31:0]    cycles with lookup tvalid=1 and tready=0
//
// err_underflow is a sticky internal debug register: set when a lookup
// reply is handed to the TOE while no lookup is outstanding.
// ---------------------------------------------------------------------------
module session_req_sequencer #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  session_req_sequencer_if.slave        s_axis_session_lup_req,
  session_req_sequencer_if.slave        s_axis_session_upd_req,
  session_req_sequencer_if.master       m_lookup_request_V,
  session_req_sequencer_if.master       m_update_request_V,
  session_req_sequencer_if.slave        s_lookup_reply_V,
  session_req_sequencer_if.slave        s_update_replay_V,
  session_req_sequencer_if.master       m_axis_session_lup_rsp,
  session_req_sequencer_if.master       m_axis_session_upd_rsp,
  output logic [3:0]                    outstanding
`ifdef SESSION_SEQ_STATS_EN
  ,
  output logic [31:0]                   stat_lup_cnt,
  output logic [31:0]                   stat_upd_cnt,
  output logic [31:0]                   stat_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    UPD_WAIT = 2'd2
  } state_t;

  state_t       state;
  logic         lup_valid;
  logic [71:0]  lup_data;
  logic         upd_valid;
  logic [87:0]  upd_data;
  logic         err_underflow;

  logic         lup_fwd;
  logic         upd_fwd;
  logic         lup_rsp_hs;
  logic         upd_rsp_hs;
  logic         lup_room;
  logic         lup_ready;
  logic         upd_ready;
  logic         lup_acc;
  logic         upd_acc;

  // Request slices drive the CAM-side master ports straight from registers.
  assign m_lookup_request_V.tvalid = lup_valid;
  assign m_lookup_request_V.tdata  = lup_data;
  assign m_update_request_V.tvalid = upd_valid;
  assign m_update_request_V.tdata  = upd_data;

  // Replies are plain wires; the counter only observes the TOE-side handshake.
  assign m_axis_session_lup_rsp.tdata  = s_lookup_reply_V.tdata;
  assign m_axis_session_lup_rsp.tvalid = s_lookup_reply_V.tvalid;
  assign s_lookup_reply_V.tready       = m_axis_session_lup_rsp.tready;
  assign m_axis_session_upd_rsp.tdata  = s_update_replay_V.tdata;
  assign m_axis_session_upd_rsp.tvalid = s_update_replay_V.tvalid;
  assign s_update_replay_V.tready      = m_axis_session_upd_rsp.tready;

  assign lup_fwd    = lup_valid & m_lookup_request_V.tready;
  assign upd_fwd    = upd_valid & m_update_request_V.tready;
  assign lup_rsp_hs = m_axis_session_lup_rsp.tvalid & m_axis_session_lup_rsp.tready;
  assign upd_rsp_hs = m_axis_session_upd_rsp.tvalid & m_axis_session_upd_rsp.tready;

  // A beat sitting in the slice is already committed to the CAM, so it counts
  // against the cap. A draining beat moves from slice to counter, leaving the
  // sum unchanged, so the same test holds whether or not the slice drains.
  assign lup_room = ({1'b0, outstanding} + {4'b0000, lup_valid}) < 5'(MAX_OUTSTANDING);

  // A pending update blocks lookups in the same cycle so the update wins.
  assign lup_ready = !ap_rst && (state == IDLE) && !s_axis_session_upd_req.tvalid
                     && (!lup_valid || m_lookup_request_V.tready) && lup_room;

  // The update is only admitted once the CAM has no lookup left to answer.
  assign upd_ready = !ap_rst && (state == DRAIN) && (outstanding == 4'd0) && !lup_valid
                     && (!upd_valid || m_update_request_V.tready);

  assign s_axis_session_lup_req.tready = lup_ready;
  assign s_axis_session_upd_req.tready = upd_ready;

  assign lup_acc = s_axis_session_lup_req.tvalid & lup_ready;
  assign upd_acc = s_axis_session_upd_req.tvalid & upd_ready;

  // Slices, in-flight counter, underflow flag and sequencing FSM.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state         <= IDLE;
      lup_valid     <= 1'b0;
      upd_valid     <= 1'b0;
      outstanding   <= 4'd0;
      err_underflow <= 1'b0;
    end else begin
      if (lup_acc) begin
        lup_valid <= 1'b1;
        lup_data  <= s_axis_session_lup_req.tdata;
      end else if (lup_fwd) begin
        lup_valid <= 1'b0;
      end

      if (upd_acc) begin
        upd_valid <= 1'b1;
        upd_data  <= s_axis_session_upd_req.tdata;
      end else if (upd_fwd) begin
        upd_valid <= 1'b0;
      end

      // Saturate at zero on a stray reply instead of wrapping.
      if (lup_fwd && !lup_rsp_hs) begin
        outstanding <= outstanding + 4'd1;
      end else if (!lup_fwd && lup_rsp_hs && (outstanding != 4'd0)) begin
        outstanding <= outstanding - 4'd1;
      end

      if (lup_rsp_hs && (outstanding == 4'd0)) begin
        err_underflow <= 1'b1;
      end

      case (state)
        IDLE:     if (s_axis_session_upd_req.tvalid) state <= DRAIN;
        DRAIN:    if (upd_acc)                       state <= UPD_WAIT;
        UPD_WAIT: if (upd_rsp_hs)                    state <= IDLE;
        default:                                     state <= IDLE;
      endcase
    end
  end

`ifdef SESSION_SEQ_STATS_EN
  // Request and stall statistics; all counters wrap.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      stat_lup_cnt   <= 32'd0;
      stat_upd_cnt   <= 32'd0;
      stat_stall_cnt <= 32'd0;
    end else begin
      if (lup_acc) begin
        stat_lup_cnt <= stat_lup_cnt + 32'd1;
      end
      if (upd_acc) begin
        stat_upd_cnt <= stat_upd_cnt + 32'd1;
      end
      if (s_axis_session_lup_req.tvalid && !lup_ready) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_session_req_sequencer.sv
// ---------------------------------------------------------------------------
// tb_session_req_sequencer
//
// Directed bench for session_req_sequencer with MAX_OUTSTANDING=8. Inputs
// change just after the falling edge and outputs are sampled there too, so
// every handshake happens on the rising edge in between. Stats ports are
// connected and checked when SESSION_SEQ_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_session_req_sequencer;

  logic ap_clk = 1'b0;
  logic ap_rst;
  logic [3:0] outstanding;

  always #5 ap_clk = ~ap_clk;

  session_req_sequencer_if #(.DATA_W(72)) lup_req ();
  session_req_sequencer_if #(.DATA_W(88)) upd_req ();
  session_req_sequencer_if #(.DATA_W(72)) lup_cam ();
  session_req_sequencer_if #(.DATA_W(88)) upd_cam ();
  session_req_sequencer_if #(.DATA_W(88)) lup_rep ();
  session_req_sequencer_if #(.DATA_W(88)) upd_rep ();
  session_req_sequencer_if #(.DATA_W(88)) lup_rsp ();
  session_req_sequencer_if #(.DATA_W(88)) upd_rsp ();

`ifdef SESSION_SEQ_STATS_EN
  logic [31:0] stat_lup_cnt;
  logic [31:0] stat_upd_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  session_req_sequencer #(.MAX_OUTSTANDING(8)) dut (
    .ap_clk                 (ap_clk),
    .ap_rst                 (ap_rst),
    .s_axis_session_lup_req (lup_req),
    .s_axis_session_upd_req (upd_req),
    .m_lookup_request_V     (lup_cam),
    .m_update_request_V     (upd_cam),
    .s_lookup_reply_V       (lup_rep),
    .s_update_replay_V      (upd_rep),
    .m_axis_session_lup_rsp (lup_rsp),
    .m_axis_session_upd_rsp (upd_rsp),
    .outstanding            (outstanding)
`ifdef SESSION_SEQ_STATS_EN
    ,
    .stat_lup_cnt           (stat_lup_cnt),
    .stat_upd_cnt           (stat_upd_cnt),
    .stat_stall_cnt         (stat_stall_cnt)
`endif
  );

  localparam logic [71:0] L0    = 72'h12_3456_789A;
  localparam logic [71:0] LBASE = 72'hA5_0000_0000_0000_0000;
  localparam logic [71:0] LA    = 72'h3C_0000_0000_0000_1000;
  localparam logic [71:0] LD    = 72'h3C_0000_0000_0000_2000;
  localparam logic [71:0] LE    = 72'h3C_0000_0000_0000_3000;
  localparam logic [87:0] R0    = 88'hAB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [87:0] U1    = 88'h55_0000_0000_0000_0000_0001;
  localparam logic [87:0] U2    = 88'h55_0000_0000_0000_0000_0002;
  localparam logic [87:0] U3    = 88'h55_0000_0000_0000_0000_0003;
  localparam logic [87:0] R1    = 88'h77_0000_0000_0000_0000_0011;
  localparam logic [87:0] R2    = 88'h77_0000_0000_0000_0000_0022;
  localparam logic [87:0] R3    = 88'h77_0000_0000_0000_0000_0033;
  localparam logic [87:0] R4    = 88'h99_8877_6655_4433_2211_00FF;

  int errors = 0;
  int checks = 0;
  int acc_cnt;
  int fwd_cnt;
  int stall_cnt;
  logic any_rdy;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [71:0] ld,
                               input logic uv, input logic [87:0] ud);
    lup_req.tvalid = lv;
    lup_req.tdata  = ld;
    upd_req.tvalid = uv;
    upd_req.tdata  = ud;
    #1;
  endtask

  task automatic applyReplies(input logic lv, input logic [87:0] ld,
                              input logic uv, input logic [87:0] ud);
    lup_rep.tvalid = lv;
    lup_rep.tdata  = ld;
    upd_rep.tvalid = uv;
    upd_rep.tdata  = ud;
    #1;
  endtask

  task automatic tick();
    @(negedge ap_clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with all downstream consumers ready.
    ap_rst         = 1'b1;
    lup_cam.tready = 1'b1;
    upd_cam.tready = 1'b1;
    lup_rsp.tready = 1'b1;
    upd_rsp.tready = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    applyReplies(1'b0, '0, 1'b0, '0);
    tick();
    tick();
    checkOutput("rst_lup_tready", lup_req.tready, 1'b0);
    checkOutput("rst_upd_tready", upd_req.tready, 1'b0);
    checkOutput("rst_lcam_tvalid", lup_cam.tvalid, 1'b0);
    checkOutput("rst_ucam_tvalid", upd_cam.tvalid, 1'b0);
    checkOutput("rst_outstanding", outstanding, 4'd0);
    checkOutput("rst_err_underflow", dut.err_underflow, 1'b0);
`ifdef SESSION_SEQ_STATS_EN
    checkOutput("rst_stat_lup", stat_lup_cnt, 32'd0);
    checkOutput("rst_stat_stall", stat_stall_cnt, 32'd0);
`endif
    ap_rst = 1'b0;
    tick();
    checkOutput("idle_lup_tready", lup_req.tready, 1'b1);

    // Single lookup round trip.
    applyStimulus(1'b1, L0, 1'b0, '0);
    checkOutput("single_lup_tready", lup_req.tready, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("single_lcam_tvalid", lup_cam.tvalid, 1'b1);
    checkOutput("single_lcam_tdata", lup_cam.tdata, L0);
    checkOutput("single_out_before_hs", outstanding, 4'd0);
    tick();
    checkOutput("single_lcam_empty", lup_cam.tvalid, 1'b0);
    checkOutput("single_out_one", outstanding, 4'd1);
    applyReplies(1'b1, R0, 1'b0, '0);
    checkOutput("single_lrsp_tvalid", lup_rsp.tvalid, 1'b1);
    checkOutput("single_lrsp_tdata", lup_rsp.tdata, R0);
    checkOutput("single_lrep_tready", lup_rep.tready, 1'b1);
    tick();
    applyReplies(1'b0, '0, 1'b0, '0);
    checkOutput("single_out_zero", outstanding, 4'd0);
    checkOutput("single_no_underflow", dut.err_underflow, 1'b0);

    // Stream 10 lookups with no replies: the cap stops acceptance at 8.
    acc_cnt   = 0;
    fwd_cnt   = 0;
    stall_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(acc_cnt < 10, LBASE + 72'(acc_cnt), 1'b0, '0);
      if (lup_cam.tvalid && lup_cam.tready) begin
        checkOutput("cap_fwd_tdata", lup_cam.tdata, LBASE + 72'(fwd_cnt));
        fwd_cnt++;
      end
      if (lup_req.tvalid) begin
        if (lup_req.tready) acc_cnt++;
        else stall_cnt++;
      end
      tick();
    end
    checkOutput("cap_accepted", acc_cnt, 8);
    checkOutput("cap_forwarded", fwd_cnt, 8);
    checkOutput("cap_lup_tready", lup_req.tready, 1'b0);
    checkOutput("cap_outstanding", outstanding, 4'd8);
`ifdef SESSION_SEQ_STATS_EN
    checkOutput("cap_stat_stall", stat_stall_cnt, 32'(stall_cnt));
    checkOutput("cap_stat_lup", stat_lup_cnt, 32'd9);
    checkOutput("cap_stat_upd", stat_upd_cnt, 32'd0);
`endif
    applyReplies(1'b1, R0, 1'b0, '0);
    tick();
    applyReplies(1'b0, '0, 1'b0, '0);
    checkOutput("cap_out_after_reply", outstanding, 4'd7);
    checkOutput("cap_ninth_tready", lup_req.tready, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("cap_ninth_tvalid", lup_cam.tvalid, 1'b1);
    checkOutput("cap_ninth_tdata", lup_cam.tdata, LBASE + 72'd8);
    tick();
    checkOutput("cap_out_refilled", outstanding, 4'd8);
    applyReplies(1'b1, R0, 1'b0, '0);
    for (int i = 0; i < 8; i++) tick();
    applyReplies(1'b0, '0, 1'b0, '0);
    checkOutput("cap_out_drained", outstanding, 4'd0);

    // Three lookups, then an update while the replies are held back.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, LA + 72'(i), 1'b0, '0);
      tick();
    end
    applyStimulus(1'b1, LD, 1'b1, U1);
    any_rdy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (lup_req.tready || upd_req.tready) any_rdy = 1'b1;
      tick();
    end
    checkOutput("drain_out_three", outstanding, 4'd3);
    for (int i = 0; i < 3; i++) begin
      applyReplies(1'b1, R0 + 88'(i), 1'b0, '0);
      if (lup_req.tready || upd_req.tready) any_rdy = 1'b1;
      tick();
    end
    applyReplies(1'b0, '0, 1'b0, '0);
    checkOutput("drain_held_until_third_reply", any_rdy, 1'b0);
    checkOutput("drain_out_zero", outstanding, 4'd0);
    checkOutput("drain_upd_tready", upd_req.tready, 1'b1);
    checkOutput("drain_lup_blocked", lup_req.tready, 1'b0);
    tick();
    applyStimulus(1'b1, LD, 1'b0, '0);
    checkOutput("drain_ucam_tvalid", upd_cam.tvalid, 1'b1);
    checkOutput("drain_ucam_tdata", upd_cam.tdata, U1);
    checkOutput("wait_lup_blocked", lup_req.tready, 1'b0);
    tick();
    checkOutput("wait_ucam_empty", upd_cam.tvalid, 1'b0);
    tick();
    checkOutput("wait_lup_still_blocked", lup_req.tready, 1'b0);
    checkOutput("wait_upd_blocked", upd_req.tready, 1'b0);
    applyReplies(1'b0, '0, 1'b1, R1);
    checkOutput("wait_ursp_tvalid", upd_rsp.tvalid, 1'b1);
    checkOutput("wait_ursp_tdata", upd_rsp.tdata, R1);
    checkOutput("wait_urep_tready", upd_rep.tready, 1'b1);
    tick();
    applyReplies(1'b0, '0, 1'b0, '0);
    checkOutput("after_upd_lup_tready", lup_req.tready, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("after_upd_lcam_tdata", lup_cam.tdata, LD);
    checkOutput("after_upd_lcam_tvalid", lup_cam.tvalid, 1'b1);
    tick();
    applyReplies(1'b1, R0, 1'b0, '0);
    tick();
    applyReplies(1'b0, '0, 1'b0, '0);
    checkOutput("after_upd_out_zero", outstanding, 4'd0);

    // Lookup and update valid together in IDLE: the update goes first.
    applyStimulus(1'b1, LE, 1'b1, U2);
    checkOutput("tie_lup_tready", lup_req.tready, 1'b0);
    checkOutput("tie_upd_tready_idle", upd_req.tready, 1'b0);
    tick();
    checkOutput("tie_upd_tready_drain", upd_req.tready, 1'b1);
    checkOutput("tie_lup_tready_drain", lup_req.tready, 1'b0);
    tick();
    applyStimulus(1'b1, LE, 1'b0, '0);
    checkOutput("tie_ucam_tvalid", upd_cam.tvalid, 1'b1);
    checkOutput("tie_ucam_tdata", upd_cam.tdata, U2);
    checkOutput("tie_lcam_idle", lup_cam.tvalid, 1'b0);
    tick();
    applyReplies(1'b0, '0, 1'b1, R2);
    tick();
    applyReplies(1'b0, '0, 1'b0, '0);
    checkOutput("tie_lup_tready_after", lup_req.tready, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("tie_lcam_tvalid", lup_cam.tvalid, 1'b1);
    checkOutput("tie_lcam_tdata", lup_cam.tdata, LE);
    tick();
    checkOutput("tie_out_one", outstanding, 4'd1);
    applyReplies(1'b1, R0, 1'b0, '0);
    tick();
    applyReplies(1'b0, '0, 1'b0, '0);

    // Reset during UPD_WAIT with the update stuck at a stalled CAM.
    applyStimulus(1'b0, '0, 1'b1, U3);
    tick();
    checkOutput("rstwait_upd_tready", upd_req.tready, 1'b1);
    upd_cam.tready = 1'b0;
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    tick();
    checkOutput("rstwait_ucam_held", upd_cam.tvalid, 1'b1);
    checkOutput("rstwait_ucam_tdata", upd_cam.tdata, U3);
    ap_rst = 1'b1;
    #1;
    checkOutput("rstwait_lup_tready_in_rst", lup_req.tready, 1'b0);
    tick();
    ap_rst = 1'b0;
    upd_cam.tready = 1'b1;
    #1;
    checkOutput("rstwait_ucam_cleared", upd_cam.tvalid, 1'b0);
    checkOutput("rstwait_out_zero", outstanding, 4'd0);
    checkOutput("rstwait_idle_lup_tready", lup_req.tready, 1'b1);
    checkOutput("rstwait_err_clear", dut.err_underflow, 1'b0);
`ifdef SESSION_SEQ_STATS_EN
    checkOutput("rstwait_stat_lup", stat_lup_cnt, 32'd0);
    checkOutput("rstwait_stat_upd", stat_upd_cnt, 32'd0);
    checkOutput("rstwait_stat_stall", stat_stall_cnt, 32'd0);
`endif
    applyReplies(1'b0, '0, 1'b1, R3);
    checkOutput("late_ursp_tvalid", upd_rsp.tvalid, 1'b1);
    checkOutput("late_ursp_tdata", upd_rsp.tdata, R3);
    tick();
    applyReplies(1'b0, '0, 1'b0, '0);
    checkOutput("late_state_idle", lup_req.tready, 1'b1);
    checkOutput("late_ucam_idle", upd_cam.tvalid, 1'b0);

    // Stray lookup reply with nothing outstanding.
    applyReplies(1'b1, R4, 1'b0, '0);
    checkOutput("stray_lrsp_tvalid", lup_rsp.tvalid, 1'b1);
    checkOutput("stray_lrsp_tdata", lup_rsp.tdata, R4);
    tick();
    applyReplies(1'b0, '0, 1'b0, '0);
    checkOutput("stray_out_zero", outstanding, 4'd0);
    checkOutput("stray_err_underflow", dut.err_underflow, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/session_req_sequencer.md
SESSION_REQ_SEQUENCER -- requirements
Module: session_req_sequencer

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 8, SHALL set the maximum number of lookup requests issued to the CAM without a reply (range 1..15).
REQ-002 ap_clk  in  1  single clock; all ports are synchronous to it.
REQ-003 ap_rst  in  1  synchronous, active-high reset.
REQ-004 s_axis_session_lup_req_tdata/tvalid/tready  in/in/out  72/1/1  lookup requests from the TOE.
REQ-005 s_axis_session_upd_req_tdata/tvalid/tready  in/in/out  88/1/1  update requests from the TOE.
REQ-006 m_lookup_request_V_TDATA/TVALID/TREADY  out/out/in  72/1/1  lookup requests to the cuckoo CAM.
REQ-007 m_update_request_V_TDATA/TVALID/TREADY  out/out/in  88/1/1  update requests to the cuckoo CAM.
REQ-008 s_lookup_reply_V_TDATA/TVALID/TREADY  in/in/out  88/1/1  lookup replies from the CAM.
REQ-009 s_update_replay_V_TDATA/TVALID/TREADY  in/in/out  88/1/1  update replies from the CAM.
REQ-010 m_axis_session_lup_rsp_tdata/tvalid/tready and m_axis_session_upd_rsp_tdata/tvalid/tready  out/out/in  88/1/1 each  replies to the TOE.
REQ-011 outstanding  out  4  current count of lookups in flight.

Function
REQ-012 Each request path SHALL be a one-entry registered slice: an accepted beat appears on the master port the next cycle, and tready is high when the slice is empty or is draining in the same cycle.
REQ-013 The reply paths SHALL be combinational pass-through, with tdata, tvalid and tready wired straight across.
REQ-014 outstanding SHALL increment on each m_lookup_request handshake and decrement on each m_axis_session_lup_rsp handshake.
REQ-015 When both events occur in the same cycle, outstanding SHALL be unchanged.
REQ-016 A lookup SHALL NOT be accepted when outstanding plus the occupancy of the lookup slice equals MAX_OUTSTANDING.
REQ-017 The FSM SHALL have three states: IDLE, DRAIN and UPD_WAIT.
REQ-018 In IDLE: lookups flow; a valid update request SHALL move the FSM to DRAIN without being accepted.
REQ-019 In DRAIN: lookup tready SHALL be 0; once outstanding is 0 and the lookup slice is empty, the update SHALL be accepted into its slice and the FSM SHALL move to UPD_WAIT.
REQ-020 In UPD_WAIT: lookup and update tready SHALL be 0; the m_axis_session_upd_rsp handshake SHALL return the FSM to IDLE.
REQ-021 When a lookup and an update are both valid in IDLE, the update SHALL win: the lookup is not accepted that cycle.
REQ-022 A lookup reply arriving while outstanding is 0 SHALL pass through unchanged, SHALL leave the counter at 0 (no wrap), and SHALL set sticky flag err_underflow (internal; visible as a debug register only).
REQ-023 An update reply arriving outside UPD_WAIT SHALL pass through and SHALL NOT change state.
REQ-024 All tdata SHALL pass through bit-exact; the block SHALL NOT interpret payloads.

Reset
REQ-025 On ap_rst=1 at a clock edge: the FSM SHALL be in IDLE, outstanding SHALL be 0, both slices SHALL be empty, all master tvalid SHALL be 0, and err_underflow SHALL be 0.
REQ-026 During reset, slave-side tready SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL discard in-flight slice contents; replies arriving after reset are handled per REQ-022/REQ-023.

Configuration
REQ-028 Macro SESSION_SEQ_STATS_EN, when defined, SHALL add output ports stat_lup_cnt (32) and stat_upd_cnt (32), each a wrapping counter of TOE-side request handshakes, and stat_stall_cnt (32), which counts cycles with lookup tvalid=1 and tready=0.
REQ-029 All stat counters SHALL be cleared by ap_rst.
REQ-030 Without SESSION_SEQ_STATS_EN, these ports and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-031 Reset, then one lookup 0x12_3456_789A with all treadys high -> m_lookup TVALID on the next cycle with identical data; outstanding=1; after the reply handshake, outstanding=0.
REQ-032 With MAX_OUTSTANDING=8, stream 10 lookups with no replies -> exactly 8 forwarded, lookup tready=0, outstanding=8; one reply -> a 9th lookup is forwarded.
REQ-033 Send 3 lookups, then an update while replies are delayed 20 cycles -> no lookup accepted and the update held until the 3rd reply; the update is forwarded 1 cycle after its acceptance; a lookup is accepted only after the update reply.
REQ-034 Lookup and update valid in the same IDLE cycle with outstanding=0 -> the update is forwarded first and the lookup after the update reply.
REQ-035 Assert ap_rst for 1 cycle during UPD_WAIT -> FSM in IDLE, outstanding=0, m_update TVALID=0; a late update reply passes through with the state unchanged.
REQ-036 Inject a lookup reply with outstanding=0 -> reply forwarded, outstanding stays 0, err_underflow=1; with SESSION_SEQ_STATS_EN, stat_stall_cnt matches the stalled cycles counted in REQ-032.
